// File: rtl/bp_cce_mmio_cfg_responder_if.sv
// Config-bus command/response channel between the I/O NoC endpoint and a tile responder.
// master drives commands and consumes responses; slave is the responder side.
interface bp_cce_mmio_cfg_responder_if
  #(parameter int msg_width_p = 127);

  logic [msg_width_p-1:0] io_cmd_i;
  logic                   io_cmd_v_i;
  logic                   io_cmd_ready_o;
  logic [msg_width_p-1:0] io_resp_o;
  logic                   io_resp_v_o;
  logic                   io_resp_yumi_i;

  modport slave (
    input  io_cmd_i,
    input  io_cmd_v_i,
    output io_cmd_ready_o,
    output io_resp_o,
    output io_resp_v_o,
    input  io_resp_yumi_i
  );

  modport master (
    output io_cmd_i,
    output io_cmd_v_i,
    input  io_cmd_ready_o,
    input  io_resp_o,
    input  io_resp_v_o,
    output io_resp_yumi_i
  );

endinterface

// File: rtl/bp_cce_mmio_cfg_responder.sv
// Per-tile config-bus responder: tile config registers and CCE microcode RAM port.
// Optional BP_CFG_RESPONDER_ERR_EN adds sticky err_o and all-ones unmapped reads.
module bp_cce_mmio_cfg_responder
  #(parameter int inst_width_p = 32
  , parameter int inst_ram_addr_width_p = 8
  , parameter int inst_ram_els_p = 256
  , parameter logic [7:0] domain_mask_reset_p = 8'h01)
  (input  logic clk_i
  , input  logic reset_i
  , input  logic [5:0] cce_id_i
  , bp_cce_mmio_cfg_responder_if.slave io
  , output logic freeze_o
  , output logic core_reset_o
  , output logic [1:0] icache_mode_o
  , output logic [1:0] dcache_mode_o
  , output logic cce_mode_o
  , output logic [7:0] domain_mask_o
  , output logic sac_mask_o
  , output logic ucode_v_o
  , output logic ucode_w_o
  , output logic [inst_ram_addr_width_p-1:0] ucode_addr_o
  , output logic [inst_width_p-1:0] ucode_data_o
  , input  logic [inst_width_p-1:0] ucode_data_i
`ifdef BP_CFG_RESPONDER_ERR_EN
  , output logic err_o
`endif
  );

  localparam logic [3:0] uc_rd_gp = 4'h0;
  localparam logic [3:0] uc_wr_gp = 4'h1;
  localparam logic [3:0] cfg_dev_gp = 4'h2;
  localparam logic [19:0] reg_freeze_gp = 20'h0;
  localparam logic [19:0] reg_reset_gp = 20'h1;
  localparam logic [19:0] reg_icache_gp = 20'h2;
  localparam logic [19:0] reg_dcache_gp = 20'h3;
  localparam logic [19:0] reg_cce_gp = 20'h4;
  localparam logic [19:0] reg_dmask_gp = 20'h5;
  localparam logic [19:0] reg_sac_gp = 20'h6;
  localparam logic [19:0] ucode_base_gp = 20'h08000;
  localparam logic [19:0] ucode_end_gp = ucode_base_gp + 20'(inst_ram_els_p);
  localparam logic [1:0] lce_mode_uncached = 2'd0;
  localparam logic cce_mode_uncached = 1'b0;

  typedef enum logic [1:0] {READY, UCODE_RD, RESP} state_e;

  state_e state_r, state_n;
  logic [62:0] hdr_r, hdr_n;
  logic [63:0] data_r, data_n;

  // Header = {msg_type, addr, size, payload}; addr = {nonlocal, cce, dev, local}
  logic [62:0] hdr;
  logic [63:0] cdata;
  logic [39:0] paddr;
  logic [19:0] la;
  logic is_wr, prefix, uc_hit, reg_hit, unmapped, accept;
  logic h_frz, h_rst, h_ic, h_dc, h_cce, h_dm, h_sac;
  logic [63:0] rd_val;

  assign hdr = io.io_cmd_i[126:64];
  assign cdata = io.io_cmd_i[63:0];
  assign paddr = hdr[58:19];
  assign la = paddr[19:0];
  assign is_wr = (hdr[62:59] == uc_wr_gp);
  assign prefix = (paddr[39:30] == '0)
    && (paddr[23:20] == cfg_dev_gp)
    && (paddr[29:24] == cce_id_i);
  assign uc_hit = prefix && (la >= ucode_base_gp) && (la < ucode_end_gp);

  assign h_frz = prefix && (la == reg_freeze_gp);
  assign h_rst = prefix && (la == reg_reset_gp);
  assign h_ic = prefix && (la == reg_icache_gp);
  assign h_dc = prefix && (la == reg_dcache_gp);
  assign h_cce = prefix && (la == reg_cce_gp);
  assign h_dm = prefix && (la == reg_dmask_gp);
  assign h_sac = prefix && (la == reg_sac_gp);
  assign reg_hit = h_frz | h_rst | h_ic | h_dc | h_cce | h_dm | h_sac;
  assign unmapped = prefix && !reg_hit && !uc_hit;
  assign accept = io.io_cmd_v_i && io.io_cmd_ready_o;

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      h_frz: rd_val = 64'(freeze_o);
      h_rst: rd_val = 64'(core_reset_o);
      h_ic: rd_val = 64'(icache_mode_o);
      h_dc: rd_val = 64'(dcache_mode_o);
      h_cce: rd_val = 64'(cce_mode_o);
      h_dm: rd_val = 64'(domain_mask_o);
      h_sac: rd_val = 64'(sac_mask_o);
`ifdef BP_CFG_RESPONDER_ERR_EN
      unmapped: rd_val = '1;
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      freeze_o <= 1'b1;
      core_reset_o <= 1'b0;
      icache_mode_o <= lce_mode_uncached;
      dcache_mode_o <= lce_mode_uncached;
      cce_mode_o <= cce_mode_uncached;
      domain_mask_o <= domain_mask_reset_p;
      sac_mask_o <= 1'b0;
    end else if (accept && is_wr) begin
      if (h_frz) freeze_o <= cdata[0];
      if (h_rst) core_reset_o <= cdata[0];
      if (h_ic) icache_mode_o <= cdata[1:0];
      if (h_dc) dcache_mode_o <= cdata[1:0];
      if (h_cce) cce_mode_o <= cdata[0];
      if (h_dm) domain_mask_o <= cdata[7:0];
      if (h_sac) sac_mask_o <= cdata[0];
    end
  end

`ifdef BP_CFG_RESPONDER_ERR_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) err_o <= 1'b0;
    else if (accept && unmapped) err_o <= 1'b1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= READY;
      hdr_r <= '0;
      data_r <= '0;
    end else begin
      state_r <= state_n;
      hdr_r <= hdr_n;
      data_r <= data_n;
    end
  end

  always_comb begin
    state_n = state_r;
    hdr_n = hdr_r;
    data_n = data_r;
    io.io_cmd_ready_o = 1'b0;
    io.io_resp_v_o = 1'b0;
    ucode_v_o = 1'b0;
    ucode_w_o = 1'b0;
    unique case (state_r)
      READY: begin
        io.io_cmd_ready_o = 1'b1;
        if (io.io_cmd_v_i) begin
          hdr_n = hdr;
          data_n = is_wr ? '0 : rd_val;
          ucode_v_o = uc_hit;
          ucode_w_o = uc_hit && is_wr;
          state_n = (uc_hit && !is_wr) ? UCODE_RD : RESP;
        end
      end
      UCODE_RD: begin
        data_n = 64'(ucode_data_i);
        state_n = RESP;
      end
      RESP: begin
        io.io_resp_v_o = 1'b1;
        if (io.io_resp_yumi_i) state_n = READY;
      end
      default: state_n = READY;
    endcase
  end

  assign ucode_addr_o = inst_ram_addr_width_p'(la - ucode_base_gp);
  assign ucode_data_o = cdata[inst_width_p-1:0];
  assign io.io_resp_o = {hdr_r, data_r};

endmodule

// File: tb/tb_bp_cce_mmio_cfg_responder.sv
// Randomized bench for bp_cce_mmio_cfg_responder against an address-map reference model.
module tb_bp_cce_mmio_cfg_responder;

  localparam logic [3:0] UC_RD = 4'h0;
  localparam logic [3:0] UC_WR = 4'h1;
  localparam logic [5:0] MY_CCE = 6'h05;
`ifdef BP_CFG_RESPONDER_ERR_EN
  localparam logic [63:0] UNMAP_RD = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] UNMAP_RD = 64'h0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i;
  logic freeze_o, core_reset_o, cce_mode_o, sac_mask_o;
  logic [1:0] icache_mode_o, dcache_mode_o;
  logic [7:0] domain_mask_o;
  logic ucode_v_o, ucode_w_o;
  logic [7:0] ucode_addr_o;
  logic [31:0] ucode_data_o, ucode_data_i;
`ifdef BP_CFG_RESPONDER_ERR_EN
  logic err_o;
`endif

  bp_cce_mmio_cfg_responder_if #(.msg_width_p(127)) bus ();

  bp_cce_mmio_cfg_responder dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .cce_id_i(MY_CCE),
    .io(bus),
    .freeze_o(freeze_o),
    .core_reset_o(core_reset_o),
    .icache_mode_o(icache_mode_o),
    .dcache_mode_o(dcache_mode_o),
    .cce_mode_o(cce_mode_o),
    .domain_mask_o(domain_mask_o),
    .sac_mask_o(sac_mask_o),
    .ucode_v_o(ucode_v_o),
    .ucode_w_o(ucode_w_o),
    .ucode_addr_o(ucode_addr_o),
    .ucode_data_o(ucode_data_o),
    .ucode_data_i(ucode_data_i)
`ifdef BP_CFG_RESPONDER_ERR_EN
    , .err_o(err_o)
`endif
  );

  // Microcode RAM the DUT drives; independent of the model's shadow copy
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (ucode_v_o) begin
      if (ucode_w_o) ram[ucode_addr_o] <= ucode_data_o;
      else ucode_data_i <= ram[ucode_addr_o];
    end
  end

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;

  logic m_freeze, m_rst, m_cm, m_sac, m_err;
  logic [1:0] m_im, m_dm;
  logic [7:0] m_dmask;
  logic [31:0] m_mem [256];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_freeze = 1'b1; m_rst = 1'b0;
    m_im = 2'd0; m_dm = 2'd0; m_cm = 1'b0;
    m_dmask = 8'h01; m_sac = 1'b0; m_err = 1'b0;
  endtask

  function automatic logic [39:0] mk(input logic [9:0] nl, input logic [5:0] cce,
                                     input logic [3:0] dev, input logic [19:0] la);
    return {nl, cce, dev, la};
  endfunction

  function automatic bit is_local(input logic [39:0] a);
    return a[39:30] == 10'd0 && a[29:24] == MY_CCE && a[23:20] == 4'h2;
  endfunction

  function automatic bit in_ucode(input logic [39:0] a);
    int la;
    la = int'(a[19:0]);
    return is_local(a) && la >= 'h8000 && la < 'h8000 + 256;
  endfunction

  // Apply one command to the model; returns expected response data
  task automatic model_cmd(input bit wr, input logic [39:0] a,
                           input logic [63:0] d, output logic [63:0] rdata);
    int la, ofs;
    la = int'(a[19:0]);
    rdata = 64'd0;
    if (!is_local(a)) return;
    if (in_ucode(a)) begin
      ofs = la - 'h8000;
      if (wr) m_mem[ofs] = d[31:0];
      else rdata = {32'd0, m_mem[ofs]};
      return;
    end
    case (la)
      0: if (wr) m_freeze = d[0]; else rdata = 64'(m_freeze);
      1: if (wr) m_rst = d[0]; else rdata = 64'(m_rst);
      2: if (wr) m_im = d[1:0]; else rdata = 64'(m_im);
      3: if (wr) m_dm = d[1:0]; else rdata = 64'(m_dm);
      4: if (wr) m_cm = d[0]; else rdata = 64'(m_cm);
      5: if (wr) m_dmask = d[7:0]; else rdata = 64'(m_dmask);
      6: if (wr) m_sac = d[0]; else rdata = 64'(m_sac);
      default: begin
        m_err = 1'b1;
        if (!wr) rdata = UNMAP_RD;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cfg_regs",
          {freeze_o, core_reset_o, icache_mode_o, dcache_mode_o,
           cce_mode_o, domain_mask_o, sac_mask_o},
          {m_freeze, m_rst, m_im, m_dm, m_cm, m_dmask, m_sac});
`ifdef BP_CFG_RESPONDER_ERR_EN
      chk("err_o", err_o, m_err);
`endif
    end
  end

  // Called at a negedge with the DUT in READY; returns at a negedge in READY
  task automatic do_cmd(input bit wr, input logic [39:0] a, input logic [63:0] d,
                        input int ydly, output logic [63:0] got);
    logic [62:0] hdr;
    logic [63:0] exp;
    bit ucrd;
    int lat;
    hdr = {wr ? UC_WR : UC_RD, a, 3'($urandom), 16'($urandom)};
    ucrd = !wr && in_ucode(a);
    bus.io_cmd_i = {hdr, d};
    bus.io_cmd_v_i = 1'b1;
    #1;
    chk("cmd_ready", bus.io_cmd_ready_o, 1'b1);
    chk("ucode_v", ucode_v_o, in_ucode(a));
    if (in_ucode(a)) begin
      chk("ucode_w", ucode_w_o, wr);
      chk("ucode_addr", ucode_addr_o, 8'(a[19:0] - 20'h08000));
      if (wr) chk("ucode_data", ucode_data_o, d[31:0]);
    end
    @(posedge clk);
    model_cmd(wr, a, d, exp);
    @(negedge clk);
    bus.io_cmd_v_i = 1'b0;
    bus.io_cmd_i = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!bus.io_resp_v_o && lat < 5) begin
      chk("ready_busy", bus.io_cmd_ready_o, 1'b0);
      @(negedge clk);
      lat++;
    end
    chk("resp_latency", lat, ucrd ? 2 : 1);
    chk("resp_hdr", bus.io_resp_o[126:64], hdr);
    chk("resp_data", bus.io_resp_o[63:0], exp);
    got = bus.io_resp_o[63:0];
    for (int i = 0; i < ydly; i++) begin
      @(negedge clk);
      chk("resp_hold", {bus.io_resp_v_o, bus.io_resp_o}, {1'b1, hdr, exp});
      chk("ready_hold", bus.io_cmd_ready_o, 1'b0);
    end
    bus.io_resp_yumi_i = 1'b1;
    @(negedge clk);
    bus.io_resp_yumi_i = 1'b0;
    chk("ready_after_yumi", {bus.io_cmd_ready_o, bus.io_resp_v_o}, 2'b10);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] got;
    logic [39:0] a;
    logic [19:0] la;
    bit wr;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'd0;
      m_mem[i] = 32'd0;
    end
    reset_i = 1'b1;
    bus.io_cmd_i = '0;
    bus.io_cmd_v_i = 1'b0;
    bus.io_resp_yumi_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    chk_on = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_freeze", freeze_o, 1'b1);
    chk("rst_core_reset", core_reset_o, 1'b0);
    chk("rst_dmask", domain_mask_o, 8'h01);
    chk("rst_ready", bus.io_cmd_ready_o, 1'b1);
    chk("rst_resp_v", bus.io_resp_v_o, 1'b0);

    do_cmd(1, mk(0, MY_CCE, 2, 20'h0), 64'h0, 0, got);
    chk("freeze_cleared", freeze_o, 1'b0);
    chk("wr_resp_zero", got, 64'h0);

    do_cmd(1, mk(0, MY_CCE, 2, 20'h08005), 64'h1234, 0, got);
    do_cmd(0, mk(0, MY_CCE, 2, 20'h08005), 64'h0, 0, got);
    chk("ucode_rd_1234", got, 64'h1234);

    do_cmd(0, mk(0, MY_CCE, 2, 20'h5), 64'h0, 10, got);
    chk("dmask_rd", got, 64'h1);

    do_cmd(1, mk(0, MY_CCE ^ 6'h01, 2, 20'h6), 64'h1, 0, got);
    chk("sac_miss", sac_mask_o, 1'b0);

    do_cmd(0, mk(0, MY_CCE, 2, 20'h7), 64'h0, 0, got);
    chk("unmapped_rd", got, UNMAP_RD);

    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom);
      case ($urandom_range(0, 6))
        0, 1: a = mk(0, MY_CCE, 2, 20'($urandom_range(0, 6)));
        2, 3: a = mk(0, MY_CCE, 2, 20'h08000 + 20'($urandom_range(0, 15)));
        4: begin
          case ($urandom_range(0, 3))
            0: la = 20'h7;
            1: la = 20'h07FFF;
            2: la = 20'h08100;
            default: la = 20'($urandom);
          endcase
          a = mk(0, MY_CCE, 2, la);
        end
        5: a = mk(0, MY_CCE ^ 6'($urandom_range(1, 63)), 2,
                  20'($urandom_range(0, 6)));
        default: a = mk(10'($urandom_range(0, 1)), MY_CCE,
                        4'($urandom_range(0, 15)) | 4'h1,
                        20'h08000 + 20'($urandom_range(0, 15)));
      endcase
      do_cmd(wr, a, {$urandom, $urandom}, $urandom_range(0, 3), got);
    end

    do_cmd(1, mk(0, MY_CCE, 2, 20'h0), 64'h0, 0, got);
    do_cmd(1, mk(0, MY_CCE, 2, 20'h5), 64'hA5, 0, got);
    bus.io_cmd_i = {UC_RD, mk(0, MY_CCE, 2, 20'h5), 19'd0, 64'd0};
    bus.io_cmd_v_i = 1'b1;
    @(posedge clk);
    model_cmd(0, mk(0, MY_CCE, 2, 20'h5), 64'h0, got);
    @(negedge clk);
    bus.io_cmd_v_i = 1'b0;
    chk("pre_rst_resp_v", bus.io_resp_v_o, 1'b1);
    reset_i = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_i = 1'b0;
    chk("rst_drop_resp", bus.io_resp_v_o, 1'b0);
    chk("rst_ready_again", bus.io_cmd_ready_o, 1'b1);
    chk("rst_freeze_again", freeze_o, 1'b1);
    chk("rst_dmask_again", domain_mask_o, 8'h01);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_cce_mmio_cfg_responder.md
Name: bp_cce_mmio_cfg_responder

Overview:
- Per-tile config-bus endpoint that terminates the uncached config traffic issued by the cfg loader.
- Accepts e_mem_msg_uc_wr / e_mem_msg_uc_rd on io_cmd, decodes the local address, and updates or reads the tile config registers and the CCE microcode RAM port.
- Returns exactly one io_resp per command so the loader's credit counter drains.
- Sits between the I/O NoC endpoint and the core/CCE/LCE config inputs.

Parameters:
- bp_params_p, e_bp_default_cfg: proc config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p, cfg_addr_width_p, dword_width_p.
- inst_width_p, "inv": CCE microcode instruction width.
- inst_ram_addr_width_p, "inv": microcode RAM address width.
- inst_ram_els_p, "inv": microcode RAM depth.
- domain_mask_reset_p, 8'h01: reset value of domain_mask_o.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- cce_id_i  in  cce_id_width_p  this tile's CCE id, compared against the address cce field.
- io_cmd_i  in  cce_mem_msg_width_lp  command message.
- io_cmd_v_i  in  1  command valid.
- io_cmd_ready_o  out  1  responder can accept (valid->ready handshake).
- io_resp_o  out  cce_mem_msg_width_lp  response message.
- io_resp_v_o  out  1  response valid.
- io_resp_yumi_i  in  1  response consumed.
- freeze_o  out  1  core freeze.
- core_reset_o  out  1  core soft reset.
- icache_mode_o  out  $bits(bp_lce_mode_e)  I$ LCE mode.
- dcache_mode_o  out  $bits(bp_lce_mode_e)  D$ LCE mode.
- cce_mode_o  out  $bits(bp_cce_mode_e)  CCE mode.
- domain_mask_o  out  8  enabled domains.
- sac_mask_o  out  1  SAC enable.
- ucode_v_o  out  1  microcode RAM access strobe.
- ucode_w_o  out  1  1 = write, 0 = read.
- ucode_addr_o  out  inst_ram_addr_width_p  RAM address.
- ucode_data_o  out  inst_width_p  write data.
- ucode_data_i  in  inst_width_p  read data, valid 1 cycle after a read strobe.

Behaviour:
- Reset values:
  - freeze_o = 1, core_reset_o = 0.
  - icache_mode_o and dcache_mode_o = e_lce_mode_uncached; cce_mode_o = e_cce_mode_uncached.
  - domain_mask_o = domain_mask_reset_p, sac_mask_o = 0.
  - io_resp_v_o = 0, ucode_v_o = 0.
  - State = READY.
- FSM states: READY, UCODE_RD, RESP.
- io_cmd_ready_o = (state == READY). Accept occurs on io_cmd_v_i & io_cmd_ready_o; the header and data are latched at accept.
- Decode at accept using the bp_local_addr_s fields of header.addr:
  - Hit requires nonlocal == 0, dev == cfg_dev_gp, cce == cce_id_i.
  - Register addresses: bp_cfg_reg_{freeze, reset, icache_mode, dcache_mode, cce_mode, domain_mask, sac_mask}_gp.
  - Microcode window: addr in [bp_cfg_mem_base_cce_ucode_gp, bp_cfg_mem_base_cce_ucode_gp + inst_ram_els_p).
- Register write hit: the register updates from the low bits of data, truncated to register width, on the accept edge. The new value is visible the next cycle. Next state = RESP.
- Register read hit: response data = register value zero-extended to dword_width_p. Next state = RESP.
- Microcode write: ucode_v_o = ucode_w_o = 1 combinationally in the accept cycle, with ucode_addr_o = addr - base and ucode_data_o = data[inst_width_p-1:0]. Next state = RESP.
- Microcode read: read strobe in the accept cycle; next state = UCODE_RD. In UCODE_RD, capture ucode_data_i zero-extended, then go to RESP.
- Miss (any field mismatch or unmapped address): writes have no side effect; reads return 0. Still responds.
- RESP:
  - io_resp_v_o = 1.
  - Header is copied from the command (msg_type, addr, payload, size).
  - data = read value for reads, 0 for writes.
  - Held stable until io_resp_yumi_i; go to READY the cycle after yumi.
- Latency, accept to io_resp_v_o: register 1 cycle, microcode read 2 cycles. Maximum throughput is 1 command per 2 cycles.
- Single outstanding command; no command is accepted while a response is pending.
- reset_i asserted in any state:
  - Next cycle: state READY, pending response dropped, all registers reset.
  - freeze_o reasserts to 1.
- Writing freeze or reset does not affect the responder itself; it continues to answer.

Optional Feature:
- Macro BP_CFG_RESPONDER_ERR_EN.
- Defined:
  - Adds output err_o (1 bit), sticky, set on any unmapped access that matched nonlocal, dev and cce. Cleared only by reset_i.
  - Unmapped reads return 64'hFFFF_FFFF_FFFF_FFFF.
- Undefined: no err_o port; unmapped reads return 0.

Test Plan:
- Reset, then idle 5 cycles -> freeze_o = 1, core_reset_o = 0, domain_mask_o = 8'h01, io_cmd_ready_o = 1, io_resp_v_o = 0.
- uc_wr bp_cfg_reg_freeze_gp data 0 -> freeze_o = 0 on the cycle after accept. io_resp_v_o 1 cycle after accept, header equal to the command, data 0.
- uc_wr ucode offset 5 data 'h1234, then uc_rd offset 5 with the RAM model returning 'h1234 -> write strobe seen with addr 5. Read response arrives 2 cycles after accept with data 'h1234.
- uc_rd bp_cfg_reg_domain_mask_gp with io_resp_yumi_i held low 10 cycles -> response stable for all 10 cycles, io_cmd_ready_o = 0 throughout. After yumi, ready returns the next cycle.
- uc_wr with cce field != cce_id_i targeting sac_mask, data 1 -> sac_mask_o stays 0; response still returned.
- reset_i pulsed while in RESP -> io_resp_v_o = 0 next cycle, state READY, registers at reset values.
